// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Drives a level interrupt into a CP0 hardware-interrupt line.
module timer_dev #(
    parameter logic [31:0] PRESET_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  ctrl_r;
    logic [3:0]  ctrl_s;
    logic [31:0] preset_r;
    logic [31:0] preset_s;
    logic [31:0] count_r;
    logic [31:0] count_s;
    logic        pend_r;
    logic        pend_s;
    logic        en_clr_s;
    logic        pend_set_s;
    logic        ctrl_wr_s;
    logic        preset_wr_s;
    logic        reload_mode_s;

    assign ctrl_wr_s     = we & (addr == 2'd0);
    assign preset_wr_s   = we & (addr == 2'd1);
    assign reload_mode_s = (ctrl_r[2:1] == 2'b01);

    // Countdown sequencing: next state, next COUNT and the INT side effects.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        en_clr_s   = 1'b0;
        pend_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ctrl_r[0]) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                count_s = preset_r;
                state_s = CNT;
            end
            CNT: begin
                // A zero preset lands here with COUNT=0 and expires like a preset of 1.
                if (!ctrl_r[0]) begin
                    state_s = IDLE;
                end else if (count_r <= 32'd1) begin
                    count_s = 32'd0;
                    state_s = INT;
                end else begin
                    count_s = count_r - 32'd1;
                    state_s = CNT;
                end
            end
            INT: begin
                if (reload_mode_s) begin
                    state_s = LOAD;
                end else begin
                    en_clr_s   = 1'b1;
                    pend_set_s = 1'b1;
                    state_s    = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Register updates where a bus write outranks the automatic INT effects.
    always_comb begin
        ctrl_s   = ctrl_r;
        preset_s = preset_r;
        pend_s   = pend_r;
        if (ctrl_wr_s) begin
            ctrl_s = din[3:0];
        end else if (en_clr_s) begin
            ctrl_s = {ctrl_r[3:1], 1'b0};
        end else begin
            ctrl_s = ctrl_r;
        end
        if (preset_wr_s) begin
            preset_s = din;
        end else begin
            preset_s = preset_r;
        end
        if (ctrl_wr_s | preset_wr_s) begin
            pend_s = 1'b0;
        end else if (pend_set_s) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // State and register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= PRESET_INIT;
            count_r  <= 32'd0;
            pend_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ctrl_r   <= ctrl_s;
            preset_r <= preset_s;
            count_r  <= count_s;
            pend_r   <= pend_s;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl_r};
            2'd1:    dout = preset_r;
            2'd2:    dout = count_r;
            default: dout = 32'd0;
        endcase
    end

    assign irq = ctrl_r[3] & ((state_r == INT) | pend_r);

endmodule
